sensor_request_dispatcher: RTL



---
 rtl/sensor_dispatch_pkg.sv | 23 ++
 rtl/timeout_counter.sv | 38 +++
 rtl/sensor_request_dispatcher.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sensor_dispatch_pkg.sv
// Shared types and constants for the sensor request dispatcher.
package sensor_dispatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ADDR,
        DISPATCH,
        WAIT_SENSOR,
        SEND_CODE,
        WAIT_CODE_DONE,
        SEND_DATA,
        WAIT_DATA_DONE
    } state_e;

    localparam logic [7:0] ERR_BAD_ADDR = 8'hE0;
    localparam logic [7:0] ERR_TIMEOUT  = 8'hE1;

    // A limit of 1 still needs a one-bit counter.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Cycle counter that flags when it has sat at LIMIT-1 while enabled; holds there.
module timeout_counter
    import sensor_dispatch_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = cnt_width(LIMIT);
    localparam logic [W-1:0] TERM = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && cnt_q != TERM) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == TERM);

endmodule

// File: rtl/sensor_request_dispatcher.sv
// Frames 2-byte UART commands, dispatches them to one sensor channel and
// serialises the 2-byte (code, data) reply back to the UART transmitter.
module sensor_request_dispatcher
    import sensor_dispatch_pkg::*;
#(
    parameter int NUM_SENSORS    = 4,
    parameter int FRAME_TIMEOUT  = 500000,
    parameter int SENSOR_TIMEOUT = 50000000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic [NUM_SENSORS-1:0]   req_enable,
    output logic [7:0]               request,
    input  logic [NUM_SENSORS-1:0]   sensor_finished,
    input  logic [8*NUM_SENSORS-1:0] sensor_response,
    input  logic [8*NUM_SENSORS-1:0] sensor_response_code,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     busy,
    output logic [7:0]               dropped_count
);

    localparam logic [8:0] NUM_S9 = 9'(NUM_SENSORS);

    state_e                 state_q, state_d;
    logic [7:0]             request_q, request_d;
    logic [7:0]             addr_q, addr_d;
    logic [7:0]             code_q, code_d;
    logic [7:0]             data_q, data_d;
    logic [NUM_SENSORS-1:0] req_en_q, req_en_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic [7:0]             dropped_q, dropped_d;

    logic       frame_exp, sensor_exp, drop;
    logic       sel_fin;
    logic [7:0] sel_resp, sel_code;

    timeout_counter #(.LIMIT(FRAME_TIMEOUT)) u_frame_tmo (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q != WAIT_ADDR),
        .enable  (state_q == WAIT_ADDR),
        .expired (frame_exp)
    );

    timeout_counter #(.LIMIT(SENSOR_TIMEOUT)) u_sensor_tmo (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q != WAIT_SENSOR),
        .enable  (state_q == WAIT_SENSOR),
        .expired (sensor_exp)
    );

    // Only the addressed channel is visible; an out-of-range address never reaches here.
    always_comb begin
        sel_fin  = 1'b0;
        sel_resp = '0;
        sel_code = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (addr_q == 8'(i)) begin
                sel_fin  = sensor_finished[i];
                sel_resp = sensor_response[8*i +: 8];
                sel_code = sensor_response_code[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        request_d  = request_q;
        addr_d     = addr_q;
        code_d     = code_q;
        data_d     = data_q;
        req_en_d   = '0;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        drop       = rx_valid && (state_q != IDLE) && (state_q != WAIT_ADDR);

        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    request_d = rx_data;
                    state_d   = WAIT_ADDR;
                end
            end
            WAIT_ADDR: begin
                if (rx_valid) begin
                    addr_d = rx_data;
                    if ({1'b0, rx_data} >= NUM_S9) begin
                        code_d  = ERR_BAD_ADDR;
                        data_d  = rx_data;
                        state_d = SEND_CODE;
                    end else begin
                        state_d = DISPATCH;
                    end
                end else if (frame_exp) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
            DISPATCH: begin
                for (int i = 0; i < NUM_SENSORS; i++) begin
                    req_en_d[i] = (addr_q == 8'(i));
                end
                state_d = WAIT_SENSOR;
            end
            WAIT_SENSOR: begin
                if (sel_fin) begin
                    code_d  = sel_code;
                    data_d  = sel_resp;
                    state_d = SEND_CODE;
                end else if (sensor_exp) begin
                    code_d  = ERR_TIMEOUT;
                    data_d  = addr_q;
                    state_d = SEND_CODE;
                end
            end
            SEND_CODE: begin
                if (!tx_busy) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = code_q;
                    state_d    = WAIT_CODE_DONE;
                end
            end
            WAIT_CODE_DONE: begin
                if (tx_done) state_d = SEND_DATA;
            end
            SEND_DATA: begin
                if (!tx_busy) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = data_q;
                    state_d    = WAIT_DATA_DONE;
                end
            end
            WAIT_DATA_DONE: begin
                if (tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        dropped_d = (drop && dropped_q != 8'hFF) ? dropped_q + 8'd1 : dropped_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            request_q  <= '0;
            addr_q     <= '0;
            code_q     <= '0;
            data_q     <= '0;
            req_en_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            request_q  <= request_d;
            addr_q     <= addr_d;
            code_q     <= code_d;
            data_q     <= data_d;
            req_en_q   <= req_en_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            dropped_q  <= dropped_d;
        end
    end

    assign req_enable    = req_en_q;
    assign request       = request_q;
    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign busy          = (state_q != IDLE);
    assign dropped_count = dropped_q;

endmodule
